lcd_reader: RTL

Read-side controller for the HD44780-style 8-bit character LCD. It generates the read bus cycles (RW=1) that the existing command/data write FSM never issues:
- busy-flag/address read (RS=0)
- data read (RS=1)
- autonomous busy-poll that waits until BF clears after a command.

It sits beside the write FSM in wb_lcd. Its rw output also disables the pad output buffer for db while a read is in progress.

---
 rtl/lcd_reader_if.sv | 40 ++++
 rtl/lcd_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_reader_if
//  Description : Request/status and LCD read-bus signals of the HD44780 read
//                controller.
//                master : request source and pad side (drives requests, db_in)
//                slave  : lcd_reader (drives rs/rw/e and completion status)
//  Signals     : rd_bf, rd_data, wait_ready : one-cycle read requests
//                db_in                      : LCD data bus from pad
//                rs, rw, e                  : LCD control strobes
//                busy, valid                : operation in progress / done pulse
//                dout, bf, addr, timeout    : captured results
//  Revision    : 1.0 - initial release
// ============================================================================
interface lcd_reader_if;
    logic       rd_bf;
    logic       rd_data;
    logic       wait_ready;
    logic [7:0] db_in;
    logic       rs;
    logic       rw;
    logic       e;
    logic       busy;
    logic       valid;
    logic [7:0] dout;
    logic       bf;
    logic [6:0] addr;
    logic       timeout;

    modport master (
        output rd_bf, rd_data, wait_ready, db_in,
        input  rs, rw, e, busy, valid, dout, bf, addr, timeout
    );

    modport slave (
        input  rd_bf, rd_data, wait_ready, db_in,
        output rs, rw, e, busy, valid, dout, bf, addr, timeout
    );
endinterface
`default_nettype wire

// File: rtl/lcd_reader.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_reader
//  Description : Read-side bus controller for an HD44780-style 8-bit LCD.
//                Issues busy-flag/address reads (rs=0), data reads (rs=1) and
//                an autonomous busy-flag poll that repeats BF reads until BF
//                clears or the poll timeout expires. rw=1 marks a read and
//                also turns the db pad driver off.
//  Ports       : clk_10m - 10 MHz clock
//                rst     - synchronous active-high reset
//                bus     - lcd_reader_if.slave (requests, LCD strobes, results)
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_reader #(
    parameter int T_AS     = 1,
    parameter int T_PW     = 3,
    parameter int T_H      = 1,
    parameter int T_LOW    = 2,
    parameter int POLL_MAX = 20000
) (
    input  wire logic   clk_10m,
    input  wire logic   rst,
    lcd_reader_if.slave bus
);

    // Zero-valued timing parameters behave as one cycle.
    localparam int c_AS_EFF   = (T_AS     < 1) ? 1 : T_AS;
    localparam int c_PW_EFF   = (T_PW     < 1) ? 1 : T_PW;
    localparam int c_H_EFF    = (T_H      < 1) ? 1 : T_H;
    localparam int c_LOW_EFF  = (T_LOW    < 1) ? 1 : T_LOW;
    localparam int c_POLL_EFF = (POLL_MAX < 1) ? 1 : POLL_MAX;

    // Phase counters are loaded with (length - 1) and the phase exits at zero.
    localparam logic [15:0] c_AS_LD    = 16'(c_AS_EFF  - 1);
    localparam logic [15:0] c_PW_LD    = 16'(c_PW_EFF  - 1);
    localparam logic [15:0] c_H_LD     = 16'(c_H_EFF   - 1);
    localparam logic [15:0] c_LOW_LD   = 16'(c_LOW_EFF - 1);
    localparam logic [16:0] c_POLL_MAX = 17'(c_POLL_EFF);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ENABLE  = 3'd2,
        S_HOLD    = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t      r_state, w_state;
    logic [15:0] r_cnt, w_cnt;
    logic [15:0] r_poll_cnt, w_poll_cnt;
    logic        r_poll, w_poll;
    logic        r_rs, w_rs;
    logic        r_rw, w_rw;
    logic        r_e, w_e;
    logic        r_busy, w_busy;
    logic        r_valid, w_valid;
    logic [7:0]  r_dout, w_dout;
    logic        r_bf, w_bf;
    logic [6:0]  r_addr, w_addr;
    logic        r_timeout, w_timeout;
    logic        w_phase_done;
    logic        w_req;

    assign w_phase_done = (r_cnt == 16'd0);
    assign w_req        = bus.wait_ready | bus.rd_bf | bus.rd_data;

    always_ff @(posedge clk_10m) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_poll_cnt <= 16'd0;
            r_poll     <= 1'b0;
            r_rs       <= 1'b0;
            r_rw       <= 1'b0;
            r_e        <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_dout     <= 8'd0;
            r_bf       <= 1'b0;
            r_addr     <= 7'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_poll_cnt <= w_poll_cnt;
            r_poll     <= w_poll;
            r_rs       <= w_rs;
            r_rw       <= w_rw;
            r_e        <= w_e;
            r_busy     <= w_busy;
            r_valid    <= w_valid;
            r_dout     <= w_dout;
            r_bf       <= w_bf;
            r_addr     <= w_addr;
            r_timeout  <= w_timeout;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = w_phase_done ? r_cnt : (r_cnt - 16'd1);
        // Poll counter runs for the whole poll and sticks at all-ones.
        w_poll_cnt = (r_poll && (r_poll_cnt != 16'hFFFF)) ? (r_poll_cnt + 16'd1) : r_poll_cnt;
        w_poll     = r_poll;
        w_rs       = r_rs;
        w_rw       = r_rw;
        w_e        = r_e;
        w_busy     = r_busy;
        w_valid    = 1'b0;
        w_dout     = r_dout;
        w_bf       = r_bf;
        w_addr     = r_addr;
        w_timeout  = r_timeout;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    // wait_ready > rd_bf > rd_data: only a lone rd_data selects rs=1.
                    w_poll     = bus.wait_ready;
                    w_rs       = ~(bus.wait_ready | bus.rd_bf);
                    w_rw       = 1'b1;
                    w_busy     = 1'b1;
                    w_timeout  = 1'b0;
                    w_poll_cnt = 16'd0;
                    w_cnt      = c_AS_LD;
                    w_state    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_phase_done) begin
                    w_e     = 1'b1;
                    w_cnt   = c_PW_LD;
                    w_state = S_ENABLE;
                end
            end
            S_ENABLE: begin
                if (w_phase_done) begin
                    // Sample the bus on the falling edge of e.
                    w_e    = 1'b0;
                    w_dout = bus.db_in;
                    if (!r_rs) begin
                        w_bf   = bus.db_in[7];
                        w_addr = bus.db_in[6:0];
                    end
                    w_cnt   = c_H_LD;
                    w_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_phase_done) begin
                    w_rw    = 1'b0;
                    w_rs    = 1'b0;
                    w_cnt   = c_LOW_LD;
                    w_state = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (w_phase_done) begin
                    if (r_poll && r_bf && ({1'b0, r_poll_cnt} < c_POLL_MAX)) begin
                        // Controller still busy and budget left: re-read BF.
                        w_rw    = 1'b1;
                        w_rs    = 1'b0;
                        w_cnt   = c_AS_LD;
                        w_state = S_SETUP;
                    end else begin
                        w_timeout = r_poll & r_bf;
                        w_poll    = 1'b0;
                        w_busy    = 1'b0;
                        w_valid   = 1'b1;
                        w_state   = S_IDLE;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.rs      = r_rs;
    assign bus.rw      = r_rw;
    assign bus.e       = r_e;
    assign bus.busy    = r_busy;
    assign bus.valid   = r_valid;
    assign bus.dout    = r_dout;
    assign bus.bf      = r_bf;
    assign bus.addr    = r_addr;
    assign bus.timeout = r_timeout;

endmodule
`default_nettype wire
